// File: rtl/asa_noc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// asa_noc_pkg : message types, packet constants and decoder states for the
//               ASA tile NoC request/response path.
// Revision    : 1.0
// ============================================================================
package asa_noc_pkg;

  localparam int         ASA_NOC_PAYLOAD_BEATS = 8;
  localparam logic [3:0] ASA_NOC_KEEP_FULL     = 4'hF;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] key;
    logic [63:0] data;
  } ASAReqMsg;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  status;
  } ASARespMsg;

  // Payload states are consecutive so the decoder can advance with +1.
  typedef enum logic [3:0] {
    HDR   = 4'd0,
    A_HI  = 4'd1,
    A_LO  = 4'd2,
    K_HI  = 4'd3,
    K_LO  = 4'd4,
    D_HI  = 4'd5,
    D_LO  = 4'd6,
    PAD0  = 4'd7,
    PAD1  = 4'd8,
    HOLD  = 4'd9,
    DRAIN = 4'd10
  } asa_noc_dec_state_e;

endpackage
`default_nettype wire

// File: rtl/asa_sat_cnt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// asa_sat_cnt : W-bit up counter that sticks at all-ones, with sync clear.
// Revision    : 1.0
// ============================================================================
module asa_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk_ctrl,
  input  logic         clk_ctrl_rst_low,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
    if (!clk_ctrl_rst_low) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (inc && (r_q != {W{1'b1}})) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/asa_noc_req_dec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// asa_noc_req_dec : rebuilds ASA request messages from 9-beat NoC packets.
// Revision        : 1.0
// ============================================================================
module asa_noc_req_dec
  import asa_noc_pkg::*;
#(
  parameter int PAYLOAD_BEATS = 8,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk_ctrl,
  input  logic                 clk_ctrl_rst_low,
  input  logic                 stream_in_TVALID,
  output logic                 stream_in_TREADY,
  input  logic [31:0]          stream_in_TDATA,
  input  logic [3:0]           stream_in_TKEEP,
  input  logic                 stream_in_TLAST,
  output logic [31:0]          header_in,
  output logic                 header_in_vld,
  output logic                 req_val,
  input  logic                 req_rdy,
  output ASAReqMsg             req_msg,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // Any other payload length is unsupported: such a build never accepts beats.
  localparam logic c_beats_ok = (PAYLOAD_BEATS == ASA_NOC_PAYLOAD_BEATS);

  asa_noc_dec_state_e r_state;
  asa_noc_dec_state_e w_next;
  logic               r_live;
  logic [31:0]        r_header;
  logic               r_hdr_vld;
  ASAReqMsg           r_msg;
  logic               w_beat;
  logic               w_keep_bad;
  logic               w_err;

  // r_live keeps TREADY low while reset is held, without a reset-to-output path.
  assign stream_in_TREADY = r_live & c_beats_ok & (r_state != HOLD);
  assign w_beat           = stream_in_TVALID & stream_in_TREADY;
  assign w_keep_bad       = (stream_in_TKEEP != ASA_NOC_KEEP_FULL);

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    unique case (r_state)
      HDR, A_HI, A_LO, K_HI, K_LO, D_HI, D_LO, PAD0: begin
        if (w_beat) begin
          if (w_keep_bad || stream_in_TLAST) begin
            w_err  = 1'b1;
            w_next = stream_in_TLAST ? HDR : DRAIN;
          end else begin
            w_next = asa_noc_dec_state_e'(r_state + 4'd1);
          end
        end
      end
      PAD1: begin
        if (w_beat) begin
          if (w_keep_bad || !stream_in_TLAST) begin
            w_err  = 1'b1;
            w_next = stream_in_TLAST ? HDR : DRAIN;
          end else begin
            w_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (req_rdy) begin
          w_next = HDR;
        end
      end
      DRAIN: begin
        if (w_beat && stream_in_TLAST) begin
          w_next = HDR;
        end
      end
      default: w_next = HDR;
    endcase
  end

  always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
    if (!clk_ctrl_rst_low) begin
      r_state   <= HDR;
      r_live    <= 1'b0;
      r_header  <= '0;
      r_hdr_vld <= 1'b0;
      r_msg     <= '0;
    end else begin
      r_live    <= 1'b1;
      r_state   <= w_next;
      r_hdr_vld <= 1'b0;
      // Header is published even for packets that later turn out bad.
      if (w_beat && (r_state == HDR)) begin
        r_header  <= stream_in_TDATA;
        r_hdr_vld <= 1'b1;
      end
      if (w_beat && !w_err) begin
        case (r_state)
          A_HI:    r_msg.addr[63:32] <= stream_in_TDATA;
          A_LO:    r_msg.addr[31:0]  <= stream_in_TDATA;
          K_HI:    r_msg.key[63:32]  <= stream_in_TDATA;
          K_LO:    r_msg.key[31:0]   <= stream_in_TDATA;
          D_HI:    r_msg.data[63:32] <= stream_in_TDATA;
          D_LO:    r_msg.data[31:0]  <= stream_in_TDATA;
          default: ;
        endcase
      end
    end
  end

  asa_sat_cnt #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk_ctrl         (clk_ctrl),
    .clk_ctrl_rst_low (clk_ctrl_rst_low),
    .inc              (w_err),
    .clr              (1'b0),
    .q                (err_cnt)
  );

  assign header_in     = r_header;
  assign header_in_vld = r_hdr_vld;
  assign req_val       = (r_state == HOLD);
  assign req_msg       = r_msg;

endmodule
`default_nettype wire
